// File: rtl/input_vc_controller_param.sv
// ---------------------------------------------------------------------------
// input_vc_controller_param
//
// Controller for one input virtual channel of a wormhole VC router. One
// instance sits beside each input VC FIFO and drives the route computation,
// VC allocation and switch allocation handshakes for the packet at the FIFO
// head. A packet walks IDLE -> VC_ALLOC -> ACTIVE. Its route and output VC
// are latched once per packet. When the tail (or single-flit packet) leaves,
// the controller releases the output VC.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   data, valid       flit at the FIFO head, FIFO not empty
//   pop               FIFO read strobe (combinational)
//   dst               destination field of the head flit, to RC
//   candidateOutPort  one-hot RC result
//   candidateOutVC    multi-hot set of permitted output VCs
//   vaReq, reqPort,
//   reqVC             VC allocation request
//   VCgranted,
//   selOutVC          VC allocation grant and the granted VC (one-hot)
//   reqSA             per-port switch allocation request
//   inputGrantSA      switch allocation grant to this VC
//   outVC             locked output VC (one-hot)
//   readyVC_all       bit p*V+v: output VC v of port p can take a flit
//   vcRelease, relPort,
//   relVC             one-cycle release of the output VC after the tail
//   state             IDLE=0, VC_ALLOC=1, ACTIVE=2
//   protocolErr       sticky protocol error flag
// ---------------------------------------------------------------------------
module input_vc_controller_param #(
    parameter int         N        = 5,
    parameter int         V        = 4,
    parameter int         DW       = 32,
    parameter int         DST_W    = 8,
    parameter logic [1:0] T_BODY   = 2'b00,
    parameter logic [1:0] T_HEAD   = 2'b01,
    parameter logic [1:0] T_TAIL   = 2'b10,
    parameter logic [1:0] T_SINGLE = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    data,
    input  logic             valid,
    output logic             pop,
    output logic [DST_W-1:0] dst,
    input  logic [N-1:0]     candidateOutPort,
    input  logic [V-1:0]     candidateOutVC,
    output logic             vaReq,
    output logic [N-1:0]     reqPort,
    output logic [V-1:0]     reqVC,
    input  logic             VCgranted,
    input  logic [V-1:0]     selOutVC,
    output logic [N-1:0]     reqSA,
    input  logic             inputGrantSA,
    output logic [V-1:0]     outVC,
    input  logic [N*V-1:0]   readyVC_all,
    output logic             vcRelease,
    output logic [N-1:0]     relPort,
    output logic [V-1:0]     relVC,
    output logic [1:0]       state,
    output logic             protocolErr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VC_ALLOC = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    state_t         state_q;
    logic [N-1:0]   route_q;
    logic [V-1:0]   vc_mask_q;
    logic [V-1:0]   out_vc_q;
    logic           first_flit_q;
    logic           protocol_err_q;
    logic           vc_release_q;
    logic [N-1:0]   rel_port_q;
    logic [V-1:0]   rel_vc_q;

    logic [1:0]     typ;
    logic           is_head_type;
    logic           is_end_type;
    logic [V-1:0]   port_ready;
    logic [V-1:0]   vc_req;
    logic           va_req_w;
    logic           out_rdy;
    logic           sa_pop;
    logic           discard;
    logic           data_unused;

    // Only the type and destination fields of the flit matter here; the
    // payload bits pass straight through the FIFO to the crossbar.
    assign data_unused = ^data;

    // Decode the flit type once. A SINGLE flit is both a head and a tail,
    // so it starts a packet and also ends it.
    assign typ          = data[DW-3:DW-4];
    assign is_head_type = (typ == T_HEAD) || (typ == T_SINGLE);
    assign is_end_type  = (typ == T_TAIL) || (typ == T_SINGLE);
    assign dst          = data[DST_W-1:0];

    // Pick the readiness vector of the downstream port the packet is routed
    // to. The route is one-hot, so the lowest set bit selects the slice. An
    // empty route falls back to port 0; requests are gated off separately
    // in that case, so the fallback never produces a request.
    always_comb begin
        port_ready = readyVC_all[V-1:0];
        for (int i = N - 1; i >= 0; i--) begin
            if (route_q[i]) begin
                port_ready = readyVC_all[i*V +: V];
            end
        end
    end

    // VC allocation asks only for permitted output VCs that are ready right
    // now. If none are ready, the request stays low and the head waits.
    assign vc_req   = vc_mask_q & port_ready;
    assign va_req_w = (state_q == VC_ALLOC) && (|route_q) && (|vc_req);
    assign vaReq    = va_req_w;
    assign reqVC    = va_req_w ? vc_req : '0;

    // Switch allocation runs per flit. A flit competes only when it sits at
    // the FIFO head and the locked downstream VC can accept it. A grant
    // without a live request is ignored and does not pop.
    assign out_rdy = |(out_vc_q & port_ready);
    assign reqSA   = ((state_q == ACTIVE) && valid && out_rdy) ? route_q : '0;
    assign sa_pop  = inputGrantSA && (|reqSA);

    // The port request follows the active request: it carries the route
    // while a VA request is live, and throughout ACTIVE.
    always_comb begin
        reqPort = '0;
        if (va_req_w || (state_q == ACTIVE)) begin
            reqPort = route_q;
        end
    end

    // A body or tail flit seen in IDLE has no head, so it is dropped
    // immediately. pop is held low during reset so that the FIFO is never
    // drained while the controller is being cleared.
    assign discard = (state_q == IDLE) && valid && !is_head_type;
    assign pop     = !rst && (sa_pop || discard);

    assign state       = state_q;
    assign outVC       = out_vc_q;
    assign protocolErr = protocol_err_q;
    assign vcRelease   = vc_release_q;
    assign relPort     = rel_port_q;
    assign relVC       = rel_vc_q;

    // Per-packet state machine. IDLE latches the route and the permitted VC
    // set from the head. The head stays in the FIFO until switch allocation
    // forwards it. VC_ALLOC waits for a grant that matches a live request.
    // ACTIVE forwards flits one per granted cycle. When the last flit
    // leaves, ACTIVE drops the VC lock and issues a one-cycle release next
    // cycle. Reset abandons any packet in flight without a release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            route_q        <= '0;
            vc_mask_q      <= '0;
            out_vc_q       <= '0;
            first_flit_q   <= 1'b0;
            protocol_err_q <= 1'b0;
            vc_release_q   <= 1'b0;
            rel_port_q     <= '0;
            rel_vc_q       <= '0;
        end else begin
            vc_release_q <= 1'b0;
            rel_port_q   <= '0;
            rel_vc_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        if (is_head_type) begin
                            route_q   <= candidateOutPort;
                            vc_mask_q <= candidateOutVC;
                            state_q   <= VC_ALLOC;
                        end else begin
                            protocol_err_q <= 1'b1;
                        end
                    end
                end
                VC_ALLOC: begin
                    if (VCgranted && va_req_w) begin
                        out_vc_q     <= selOutVC;
                        first_flit_q <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sa_pop) begin
                        first_flit_q <= 1'b0;
                        if ((typ == T_HEAD) && !first_flit_q) begin
                            protocol_err_q <= 1'b1;
                        end
                        if (is_end_type) begin
                            vc_release_q <= 1'b1;
                            rel_port_q   <= route_q;
                            rel_vc_q     <= out_vc_q;
                            out_vc_q     <= '0;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_vc_controller_param.sv
// ---------------------------------------------------------------------------
// tb_input_vc_controller_param
//
// Directed bench for input_vc_controller_param. A queue models the input
// FIFO. The bench pops the queue whenever the DUT strobes pop. Expected
// output-VC releases are queued when a packet is enqueued, and they are
// compared when the DUT pulses vcRelease.
// ---------------------------------------------------------------------------
module tb_input_vc_controller_param;

    localparam int N     = 5;
    localparam int V     = 4;
    localparam int DW    = 32;
    localparam int DST_W = 8;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    data;
    logic             valid;
    logic             pop;
    logic [DST_W-1:0] dst;
    logic [N-1:0]     candidateOutPort;
    logic [V-1:0]     candidateOutVC;
    logic             vaReq;
    logic [N-1:0]     reqPort;
    logic [V-1:0]     reqVC;
    logic             VCgranted;
    logic [V-1:0]     selOutVC;
    logic [N-1:0]     reqSA;
    logic             inputGrantSA;
    logic [V-1:0]     outVC;
    logic [N*V-1:0]   readyVC_all;
    logic             vcRelease;
    logic [N-1:0]     relPort;
    logic [V-1:0]     relVC;
    logic [1:0]       state;
    logic             protocolErr;

    typedef struct packed {
        logic [N-1:0] port;
        logic [V-1:0] vc;
    } rel_t;

    logic [DW-1:0] fifo[$];
    rel_t          relExp[$];
    int            passed       = 0;
    int            total        = 0;
    int            releaseCount = 0;
    int            popCount     = 0;
    int            base;
    int            popBase;

    input_vc_controller_param #(
        .N(N), .V(V), .DW(DW), .DST_W(DST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .valid(valid),
        .pop(pop),
        .dst(dst),
        .candidateOutPort(candidateOutPort),
        .candidateOutVC(candidateOutVC),
        .vaReq(vaReq),
        .reqPort(reqPort),
        .reqVC(reqVC),
        .VCgranted(VCgranted),
        .selOutVC(selOutVC),
        .reqSA(reqSA),
        .inputGrantSA(inputGrantSA),
        .outVC(outVC),
        .readyVC_all(readyVC_all),
        .vcRelease(vcRelease),
        .relPort(relPort),
        .relVC(relVC),
        .state(state),
        .protocolErr(protocolErr)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Global time limit so the run always ends even if the flow stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [DW-1:0] mkFlit(input logic [1:0] typ, input logic [7:0] d);
        logic [DW-1:0] f;
        f = '0;
        f[DW-3:DW-4] = typ;
        f[7:0] = d;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic refreshFifo();
        valid = (fifo.size() > 0);
        data  = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic expectRelease(input logic [N-1:0] p, input logic [V-1:0] v);
        rel_t r;
        r.port = p;
        r.vc   = v;
        relExp.push_back(r);
    endtask

    // Drive the per-cycle grant inputs, then let combinational outputs settle
    // well ahead of the next rising edge.
    task automatic applyStimulus(input logic vcg, input logic [V-1:0] sel, input logic sag);
        VCgranted    = vcg;
        selOutVC     = sel;
        inputGrantSA = sag;
        #2;
    endtask

    // Sample pop and vcRelease before the edge, compare any release against
    // the scoreboard, then step past the edge and update the FIFO model.
    task automatic sampleAndAdvance();
        logic popSeen;
        rel_t e;
        popSeen = pop;
        if (vcRelease) begin
            releaseCount++;
            if (relExp.size() > 0) begin
                e = relExp.pop_front();
                checkOutput("relPort", 32'(relPort), 32'(e.port));
                checkOutput("relVC", 32'(relVC), 32'(e.vc));
            end else begin
                checkOutput("unexpected_release", 32'(vcRelease), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        if (popSeen && fifo.size() > 0) begin
            fifo.delete(0);
            popCount++;
        end
        refreshFifo();
    endtask

    initial begin
        rst = 1'b1;
        candidateOutPort = '0;
        candidateOutVC   = '0;
        VCgranted        = 1'b0;
        selOutVC         = '0;
        inputGrantSA     = 1'b0;
        readyVC_all      = '0;
        fifo.push_back(mkFlit(T_BODY, 8'h00));
        refreshFifo();
        repeat (2) @(posedge clk);
        #3;

        // Reset state, with a stray body flit present at the FIFO head.
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pop", 32'(pop), 32'd0);
        checkOutput("rst_vaReq", 32'(vaReq), 32'd0);
        checkOutput("rst_reqSA", 32'(reqSA), 32'd0);
        checkOutput("rst_outVC", 32'(outVC), 32'd0);
        checkOutput("rst_protocolErr", 32'(protocolErr), 32'd0);
        checkOutput("rst_vcRelease", 32'(vcRelease), 32'd0);
        fifo.delete();
        refreshFifo();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-flit packet to port 2. Only VC 2 of the permitted set is ready.
        $display("[TB] single-flit packet");
        candidateOutPort = 5'b00100;
        candidateOutVC   = 4'b0110;
        readyVC_all      = 20'h00400;
        fifo.push_back(mkFlit(T_SINGLE, 8'h2A));
        expectRelease(5'b00100, 4'b0100);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s1_idle_state", 32'(state), 32'd0);
        checkOutput("s1_idle_pop", 32'(pop), 32'd0);
        checkOutput("s1_dst", 32'(dst), 32'h2A);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("s1_va_state", 32'(state), 32'd1);
        checkOutput("s1_vaReq", 32'(vaReq), 32'd1);
        checkOutput("s1_reqVC", 32'(reqVC), 32'b0100);
        checkOutput("s1_reqPort", 32'(reqPort), 32'b00100);
        checkOutput("s1_va_reqSA", 32'(reqSA), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s1_active_state", 32'(state), 32'd2);
        checkOutput("s1_outVC", 32'(outVC), 32'b0100);
        checkOutput("s1_reqSA", 32'(reqSA), 32'b00100);
        checkOutput("s1_nogrant_pop", 32'(pop), 32'd0);
        checkOutput("s1_active_vaReq", 32'(vaReq), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s1_grant_pop", 32'(pop), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s1_end_state", 32'(state), 32'd0);
        checkOutput("s1_vcRelease", 32'(vcRelease), 32'd1);
        checkOutput("s1_outVC_cleared", 32'(outVC), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s1_release_pulse_end", 32'(vcRelease), 32'd0);
        sampleAndAdvance();

        // Four-flit packet to port 1 with switch allocation granted every cycle.
        $display("[TB] four-flit packet, back-to-back");
        base    = releaseCount;
        popBase = popCount;
        candidateOutPort = 5'b00010;
        candidateOutVC   = 4'b1111;
        readyVC_all      = 20'h000F0;
        fifo.push_back(mkFlit(T_HEAD, 8'h11));
        fifo.push_back(mkFlit(T_BODY, 8'h12));
        fifo.push_back(mkFlit(T_BODY, 8'h13));
        fifo.push_back(mkFlit(T_TAIL, 8'h14));
        expectRelease(5'b00010, 4'b0010);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s2_idle_pop", 32'(pop), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("s2_vaReq", 32'(vaReq), 32'd1);
        checkOutput("s2_reqVC", 32'(reqVC), 32'b1111);
        sampleAndAdvance();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            checkOutput("s2_state", 32'(state), 32'd2);
            checkOutput("s2_pop", 32'(pop), 32'd1);
            checkOutput("s2_reqSA", 32'(reqSA), 32'b00010);
            checkOutput("s2_no_early_release", 32'(vcRelease), 32'd0);
            sampleAndAdvance();
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s2_end_state", 32'(state), 32'd0);
        checkOutput("s2_vcRelease", 32'(vcRelease), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s2_release_pulse_end", 32'(vcRelease), 32'd0);
        checkOutput("s2_release_count", 32'(releaseCount - base), 32'd1);
        checkOutput("s2_pop_count", 32'(popCount - popBase), 32'd4);
        sampleAndAdvance();

        // The locked VC stops accepting flits for three cycles in mid-packet.
        $display("[TB] downstream back-pressure");
        popBase = popCount;
        candidateOutPort = 5'b01000;
        candidateOutVC   = 4'b0011;
        readyVC_all      = 20'h01000;
        fifo.push_back(mkFlit(T_HEAD, 8'h21));
        fifo.push_back(mkFlit(T_BODY, 8'h22));
        fifo.push_back(mkFlit(T_BODY, 8'h23));
        fifo.push_back(mkFlit(T_TAIL, 8'h24));
        expectRelease(5'b01000, 4'b0001);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("s3_reqVC", 32'(reqVC), 32'b0001);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s3_head_pop", 32'(pop), 32'd1);
        sampleAndAdvance();
        readyVC_all = 20'h00000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            checkOutput("s3_stall_reqSA", 32'(reqSA), 32'd0);
            checkOutput("s3_stall_pop", 32'(pop), 32'd0);
            checkOutput("s3_stall_state", 32'(state), 32'd2);
            sampleAndAdvance();
        end
        readyVC_all = 20'h01000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            checkOutput("s3_resume_pop", 32'(pop), 32'd1);
            sampleAndAdvance();
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s3_end_state", 32'(state), 32'd0);
        checkOutput("s3_vcRelease", 32'(vcRelease), 32'd1);
        checkOutput("s3_no_loss", 32'(popCount - popBase), 32'd4);
        sampleAndAdvance();

        // No permitted VC is ready, so VA is never requested and a stray grant is ignored.
        $display("[TB] VC allocation with no ready VC");
        candidateOutPort = 5'b00100;
        candidateOutVC   = 4'b0110;
        readyVC_all      = 20'h00000;
        fifo.push_back(mkFlit(T_SINGLE, 8'h31));
        expectRelease(5'b00100, 4'b0100);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        sampleAndAdvance();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 1, 4'b0100, 1'b0);
            checkOutput("s4_vaReq_low", 32'(vaReq), 32'd0);
            checkOutput("s4_state_held", 32'(state), 32'd1);
            checkOutput("s4_reqVC_zero", 32'(reqVC), 32'd0);
            sampleAndAdvance();
        end
        readyVC_all = 20'h00400;
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("s4_vaReq_ready", 32'(vaReq), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s4_active_pop", 32'(pop), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s4_vcRelease", 32'(vcRelease), 32'd1);
        sampleAndAdvance();

        // A body flit arrives in IDLE. It is dropped and the error flag stays set.
        $display("[TB] orphan body flit");
        candidateOutPort = 5'b10000;
        candidateOutVC   = 4'b0001;
        readyVC_all      = 20'h10000;
        fifo.push_back(mkFlit(T_BODY, 8'h41));
        fifo.push_back(mkFlit(T_SINGLE, 8'h42));
        expectRelease(5'b10000, 4'b0001);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s5_discard_pop", 32'(pop), 32'd1);
        checkOutput("s5_err_before", 32'(protocolErr), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s5_err_set", 32'(protocolErr), 32'd1);
        checkOutput("s5_head_no_pop", 32'(pop), 32'd0);
        checkOutput("s5_dst", 32'(dst), 32'h42);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("s5_vaReq", 32'(vaReq), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s5_reqSA", 32'(reqSA), 32'b10000);
        checkOutput("s5_pop", 32'(pop), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s5_vcRelease", 32'(vcRelease), 32'd1);
        checkOutput("s5_err_sticky", 32'(protocolErr), 32'd1);
        sampleAndAdvance();

        // Reset asserted in mid-packet: the packet is abandoned with no release.
        $display("[TB] reset mid-packet");
        candidateOutPort = 5'b00010;
        candidateOutVC   = 4'b0100;
        readyVC_all      = 20'h00040;
        fifo.push_back(mkFlit(T_HEAD, 8'h51));
        fifo.push_back(mkFlit(T_BODY, 8'h52));
        fifo.push_back(mkFlit(T_TAIL, 8'h53));
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b0100, 1'b0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s6_head_pop", 32'(pop), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s6_pre_rst_reqSA", 32'(reqSA), 32'b00010);
        rst = 1'b1;
        #1;
        checkOutput("s6_rst_state", 32'(state), 32'd0);
        checkOutput("s6_rst_reqSA", 32'(reqSA), 32'd0);
        checkOutput("s6_rst_outVC", 32'(outVC), 32'd0);
        checkOutput("s6_rst_pop", 32'(pop), 32'd0);
        checkOutput("s6_rst_err_clear", 32'(protocolErr), 32'd0);
        fifo.delete();
        refreshFifo();
        inputGrantSA = 1'b0;
        sampleAndAdvance();
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s6_no_release", 32'(vcRelease), 32'd0);
        checkOutput("s6_idle", 32'(state), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s6_no_release_later", 32'(vcRelease), 32'd0);
        sampleAndAdvance();

        // A second head inside an active packet flags an error but is still forwarded.
        $display("[TB] head inside active packet");
        popBase = popCount;
        candidateOutPort = 5'b00001;
        candidateOutVC   = 4'b1000;
        readyVC_all      = 20'h00008;
        fifo.push_back(mkFlit(T_HEAD, 8'h61));
        fifo.push_back(mkFlit(T_HEAD, 8'h62));
        fifo.push_back(mkFlit(T_TAIL, 8'h63));
        expectRelease(5'b00001, 4'b1000);
        refreshFifo();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        sampleAndAdvance();
        applyStimulus(1'b1, 4'b1000, 1'b0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s7_first_pop", 32'(pop), 32'd1);
        checkOutput("s7_err_clean", 32'(protocolErr), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s7_dup_head_pop", 32'(pop), 32'd1);
        checkOutput("s7_err_not_yet", 32'(protocolErr), 32'd0);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("s7_tail_pop", 32'(pop), 32'd1);
        checkOutput("s7_err_set", 32'(protocolErr), 32'd1);
        sampleAndAdvance();
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("s7_vcRelease", 32'(vcRelease), 32'd1);
        checkOutput("s7_pop_count", 32'(popCount - popBase), 32'd3);
        sampleAndAdvance();

        checkOutput("release_queue_drained", 32'(relExp.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/input_vc_controller_param.md
Name: input_vc_controller_param

Overview:
- Parametrised next-generation controller for one input virtual channel of a wormhole VC router; one instance per input VC.
- Explicit per-packet state machine: IDLE -> VC_ALLOC -> ACTIVE.
- Latches route and output VC once per packet and requests VC allocation only for downstream VCs that are ready.
- Requests switch allocation per flit, pops the input FIFO on grant, supports single-flit packets, emits an output-VC release pulse and flags protocol errors.
- Sits between the input FIFO and the RC, VA and SA units; non-pipelined router.

Parameters:
N, 5, number of router ports.
V, 4, VCs per port.
DW, 32, flit width; type field is data[DW-3:DW-4].
DST_W, 8, destination field width, data[DST_W-1:0].
T_BODY, 2'b00, body flit type encoding.
T_HEAD, 2'b01, head flit type encoding.
T_TAIL, 2'b10, tail flit type encoding.
T_SINGLE, 2'b11, head+tail (single-flit packet) type encoding.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
data  in  DW  flit at the FIFO head.
valid  in  1  FIFO not empty.
pop  out  1  FIFO read strobe.
dst  out  DST_W  data[DST_W-1:0], combinational to RC.
candidateOutPort  in  N  RC result, one-hot.
candidateOutVC  in  V  permitted output VCs, multi-hot.
vaReq  out  1  VA request valid.
reqPort  out  N  requested output port, one-hot.
reqVC  out  V  requested output VCs.
VCgranted  in  1  VA grant.
selOutVC  in  V  granted output VC, one-hot.
reqSA  out  N  per-port SA request.
inputGrantSA  in  1  SA grant to this VC.
outVC  out  V  locked output VC, one-hot.
readyVC_all  in  N*V  bit p*V+v = output VC v of port p can accept a flit.
vcRelease  out  1  one-cycle pulse when the tail leaves.
relPort  out  N  port being released (valid with vcRelease).
relVC  out  V  VC being released.
state  out  2  IDLE=0, VC_ALLOC=1, ACTIVE=2.
protocolErr  out  1  sticky error flag.

Behaviour:
Reset (async, rst=1), all registered:
- state=IDLE; route, outVC and protocolErr cleared.
- vcRelease=0.
- All request outputs 0.
- pop=0.

Flit type: typ = data[DW-3:DW-4].

IDLE:
- valid & typ in {HEAD, SINGLE}: register candidateOutPort -> route and candidateOutVC -> vcMask; next state VC_ALLOC. No pop; the head stays in the FIFO.
- valid & typ in {BODY, TAIL}: pop=1 (discard), protocolErr<=1, stay IDLE.

VC_ALLOC:
- vcReq = vcMask & readyVC_all[port(route)*V +: V].
- vaReq = |vcReq; reqVC = vcReq; reqPort = route.
- VCgranted & vaReq: outVC<=selOutVC; next state ACTIVE.
- VCgranted while vaReq=0, or in any other state: ignored.

ACTIVE:
- rdy = |(outVC & readyVC_all[port(route)*V +: V]).
- reqSA = valid & rdy ? route : 0 (combinational). reqPort = route.
- inputGrantSA & |reqSA: pop=1 in the same cycle (combinational).
- Popped typ in {TAIL, SINGLE}: next state IDLE; vcRelease=1 next cycle with relPort=route, relVC=outVC; outVC cleared.
- Popped typ = HEAD while ACTIVE (not the first flit): protocolErr<=1; flit still forwarded.
- inputGrantSA without reqSA: ignored, no pop.

Outputs by state:
- reqSA=0 outside ACTIVE. vaReq=0 outside VC_ALLOC.
- Bus outputs are 0 when their request is inactive.

Latency:
- Head arrival -> vaReq: 1 cycle.
- Grant -> first reqSA: 1 cycle.
- Back-to-back flits: one per cycle when grants are continuous.
- Tail pop -> IDLE and vcRelease: 1 cycle.
- Next head -> vaReq: 1 cycle after IDLE.

Other rules:
- port(route) is the index of the one-hot bit; route=0 reads port 0 but yields no requests.
- protocolErr clears only on rst.
- rst mid-packet: immediate IDLE, no vcRelease, lock dropped.

Test Plan:
- Single-flit packet, N=5/V=4, candidateOutPort=5'b00100, candidateOutVC=4'b0110, readyVC port2=4'b0100 -> vaReq with reqVC=4'b0100 on cycle 1; grant selOutVC=4'b0100 -> reqSA=5'b00100 on cycle 2; grant -> pop, then vcRelease with relPort=5'b00100, relVC=4'b0100, state=IDLE.
- 4-flit packet HEAD,BODY,BODY,TAIL with SA granted every cycle -> 4 consecutive pops, exactly one vcRelease pulse, after the tail only.
- In ACTIVE, locked VC readiness drops for 3 cycles -> reqSA=0 and pop=0 for those 3 cycles, resumes when ready returns; no flit loss.
- In VC_ALLOC, readyVC port2=0 -> vaReq=0 indefinitely; VCgranted pulsed -> ignored, state stays 1.
- BODY flit at IDLE -> pop=1 for 1 cycle, protocolErr=1 and stays 1 through the following valid packet.
- rst asserted in ACTIVE mid-packet -> state=0, reqSA=0, outVC=0 asynchronously, no vcRelease.
